// File: rtl/dout_writer.sv
// Four-lane ADC serial frame transmitter: drdy strobe, dclk, din0..din3.
// Optional status word per lane enabled by DOUT_WRITER_STATUS_EN.
module dout_writer #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned DRDY_LEN = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick_i,
  input  logic [23:0] ch1_i,
  input  logic [23:0] ch2_i,
  input  logic [23:0] ch3_i,
  input  logic [23:0] ch4_i,
  input  logic [23:0] ch5_i,
  input  logic [23:0] ch6_i,
  input  logic [23:0] ch7_i,
  input  logic [23:0] ch8_i,
  output logic        drdy_o,
  output logic        dclk_o,
  output logic [3:0]  dout_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        overrun_o
);

`ifdef DOUT_WRITER_STATUS_EN
  localparam int unsigned LANE_W = 72;
`else
  localparam int unsigned LANE_W = 48;
`endif
  localparam int unsigned DRDY_CYC = DRDY_LEN * 2 * CLK_DIV;
  localparam int unsigned PER_CYC  = 2 * CLK_DIV;
  localparam int unsigned CNT_MAX  = (DRDY_CYC > PER_CYC) ? DRDY_CYC : PER_CYC;
  localparam int unsigned CNT_W    = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned BIT_W    = $clog2(LANE_W);

  typedef enum logic [1:0] {S_IDLE, S_DRDY, S_SHIFT} state_t;

  state_t                        state_q;
  logic [CNT_W-1:0]              cnt_q;
  logic [BIT_W-1:0]              bit_q;
  logic [3:0][LANE_W-1:0]        sh_q;
  logic                          drdy_q, dclk_q, busy_q, done_q, overrun_q;
  logic [3:0]                    dout_q;
  logic [23:0]                   ch [8];
`ifdef DOUT_WRITER_STATUS_EN
  logic [15:0]                   frame_cnt_q;
`endif

  assign ch[0] = ch1_i;
  assign ch[1] = ch2_i;
  assign ch[2] = ch3_i;
  assign ch[3] = ch4_i;
  assign ch[4] = ch5_i;
  assign ch[5] = ch6_i;
  assign ch[6] = ch7_i;
  assign ch[7] = ch8_i;

  // Frame sequencer; every output is a register updated one cycle ahead.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      sh_q      <= '0;
      drdy_q    <= 1'b1;
      dclk_q    <= 1'b0;
      dout_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
`ifdef DOUT_WRITER_STATUS_EN
      frame_cnt_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      if (tick_i && state_q != S_IDLE) overrun_q <= 1'b1;
      unique case (state_q)
        S_IDLE: begin
          dclk_q <= 1'b0;
          dout_q <= '0;
          if (tick_i) begin
            for (int k = 0; k < 4; k++) begin
`ifdef DOUT_WRITER_STATUS_EN
              sh_q[k] <= {8'hA5, frame_cnt_q, ch[2*k], ch[2*k+1]};
`else
              sh_q[k] <= {ch[2*k], ch[2*k+1]};
`endif
            end
            state_q <= S_DRDY;
            drdy_q  <= 1'b0;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            bit_q   <= '0;
          end
        end
        S_DRDY: begin
          if (cnt_q == CNT_W'(DRDY_CYC - 1)) begin
            state_q <= S_SHIFT;
            drdy_q  <= 1'b1;
            cnt_q   <= '0;
            for (int k = 0; k < 4; k++) begin
              dout_q[k] <= sh_q[k][LANE_W-1];
              sh_q[k]   <= sh_q[k] << 1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_SHIFT: begin
          if (cnt_q == CNT_W'(PER_CYC - 1)) begin
            cnt_q  <= '0;
            dclk_q <= 1'b0;
            if (bit_q == BIT_W'(LANE_W - 1)) begin
              state_q <= S_IDLE;
              dout_q  <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
`ifdef DOUT_WRITER_STATUS_EN
              frame_cnt_q <= frame_cnt_q + 16'd1;
`endif
            end else begin
              bit_q <= bit_q + BIT_W'(1);
              // Next bit goes out on the first low cycle of its period.
              for (int k = 0; k < 4; k++) begin
                dout_q[k] <= sh_q[k][LANE_W-1];
                sh_q[k]   <= sh_q[k] << 1;
              end
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(CLK_DIV - 1)) dclk_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign drdy_o    = drdy_q;
  assign dclk_o    = dclk_q;
  assign dout_o    = dout_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign overrun_o = overrun_q;

endmodule

// File: tb/tb_dout_writer.sv
// Self-checking bench for dout_writer: a serial reader model rebuilds lane words from dclk edges.
module tb_dout_writer;
  localparam int CD = 4;
  localparam int DL = 1;
`ifdef DOUT_WRITER_STATUS_EN
  localparam int LB = 72;
  localparam logic [3:0] FIRST4 = 4'b1010;
`else
  localparam int LB = 48;
  localparam logic [3:0] FIRST4 = 4'b1000;
`endif
  localparam int FRAME = 2 * CD * (DL + LB);

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tick = 1'b0;
  logic [23:0] ch_in [8];
  logic        drdy_o, dclk_o, busy_o, done_o, overrun_o;
  logic [3:0]  dout_o;

  dout_writer #(.CLK_DIV(CD), .DRDY_LEN(DL)) dut (
    .clk(clk), .reset(reset), .tick_i(tick),
    .ch1_i(ch_in[0]), .ch2_i(ch_in[1]), .ch3_i(ch_in[2]), .ch4_i(ch_in[3]),
    .ch5_i(ch_in[4]), .ch6_i(ch_in[5]), .ch7_i(ch_in[6]), .ch8_i(ch_in[7]),
    .drdy_o(drdy_o), .dclk_o(dclk_o), .dout_o(dout_o),
    .busy_o(busy_o), .done_o(done_o), .overrun_o(overrun_o)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          fc = 0;
  logic [23:0] cur [8];
  logic [23:0] nxt [8];
  logic [71:0] rx [4];
  int          done_cyc, drdy_first, drdy_last, rises, viol, dones;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected lane content from the captured samples and completed-frame count.
  function automatic logic [71:0] exp_lane(input int k);
`ifdef DOUT_WRITER_STATUS_EN
    return {8'hA5, 16'(fc), cur[2*k], cur[2*k+1]};
`else
    return {24'h0, cur[2*k], cur[2*k+1]};
`endif
  endfunction

  task automatic start_tick();
    @(negedge clk);
    for (int i = 0; i < 8; i++) ch_in[i] = nxt[i];
    tick = 1'b1;
  endtask

  task automatic run_frame(input int inj, input bit chain, input bit scramble);
    int cyc;
    bit prev;
    cyc = 0;
    prev = 1'b0;
    for (int i = 0; i < 8; i++) cur[i] = nxt[i];
    for (int k = 0; k < 4; k++) rx[k] = '0;
    done_cyc = -1; drdy_first = -1; drdy_last = -1; rises = 0; viol = 0;
    while (done_cyc < 0 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      tick = (cyc == inj);
      if (scramble) for (int i = 0; i < 8; i++) ch_in[i] = 24'($urandom);
      if (!drdy_o) begin
        if (drdy_first < 0) drdy_first = cyc;
        drdy_last = cyc;
        if (dclk_o) viol++;
      end
      if (dclk_o && !prev) begin
        rises++;
        for (int k = 0; k < 4; k++) rx[k] = {rx[k][70:0], dout_o[k]};
      end
      prev = dclk_o;
      if (done_o) done_cyc = cyc;
      else if (!busy_o) viol++;
      if (done_o && chain) begin
        for (int i = 0; i < 8; i++) begin
          nxt[i] = 24'($urandom);
          ch_in[i] = nxt[i];
        end
        tick = 1'b1;
      end
    end
    chk("frame_len", 72'(done_cyc), 72'(FRAME + 1));
    chk("drdy_first", 72'(drdy_first), 72'd1);
    chk("drdy_last", 72'(drdy_last), 72'(2 * CD * DL));
    chk("dclk_rises", 72'(rises), 72'(LB));
    chk("frame_viol", 72'(viol), 72'd0);
    chk("done_busy", 72'(busy_o), 72'd0);
    chk("done_dclk", 72'(dclk_o), 72'd0);
    chk("done_dout", 72'(dout_o), 72'd0);
    for (int k = 0; k < 4; k++) chk($sformatf("lane%0d", k), rx[k], exp_lane(k));
    fc++;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) ch_in[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_drdy", 72'(drdy_o), 72'd1);
    chk("rst_busy", 72'(busy_o), 72'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_state", 72'({drdy_o, dclk_o, dout_o, busy_o, done_o, overrun_o}), 72'b1_0_0000_0_0_0);

    // Directed patterns, chained into random frames with a mid-frame tick.
    nxt[0] = 24'h800001; nxt[1] = 24'h7FFFFE; nxt[2] = 24'h123456; nxt[3] = 24'hABCDEF;
    nxt[4] = 24'h0F0F0F; nxt[5] = 24'hF0F0F0; nxt[6] = 24'hC3C3C3; nxt[7] = 24'h3C5A96;
    start_tick();
    run_frame(0, 1'b1, 1'b0);
    chk("lane0_first4", 72'(rx[0][LB-1 -: 4]), 72'(FIRST4));
    chk("overrun_a", 72'(overrun_o), 72'd0);
    run_frame(0, 1'b1, 1'b1);
    chk("overrun_b2b", 72'(overrun_o), 72'd0);
    run_frame(100, 1'b1, 1'b1);
    chk("overrun_set", 72'(overrun_o), 72'd1);
    run_frame(0, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    chk("overrun_held", 72'(overrun_o), 72'd1);
    chk("idle_busy", 72'(busy_o), 72'd0);

    // Reset mid-SHIFT aborts the frame.
    for (int i = 0; i < 8; i++) nxt[i] = 24'($urandom);
    start_tick();
    @(negedge clk);
    tick = 1'b0;
    repeat (198) @(negedge clk);
    chk("mid_busy", 72'(busy_o), 72'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_state", 72'({drdy_o, dclk_o, dout_o, busy_o, done_o, overrun_o}), 72'b1_0_0000_0_0_0);
    fc = 0;
    dones = 0;
    repeat (400) begin
      @(negedge clk);
      if (done_o || busy_o) dones++;
    end
    chk("abort_no_done", 72'(dones), 72'd0);

    // Reset wins over a simultaneous tick.
    reset = 1'b1;
    tick = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tick = 1'b0;
    chk("prio_busy", 72'(busy_o), 72'd0);
    @(negedge clk);
    chk("prio_drdy", 72'({drdy_o, busy_o}), 72'b10);

    for (int i = 0; i < 8; i++) nxt[i] = 24'($urandom);
    start_tick();
    run_frame(0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
